// File: rtl/dbg_sba_axi_bridge_pkg.sv
// Shared types for the debug SBA -> AXI4 bridge.
// Contents:
//  - AXI4 master request/response structs (64-bit address/data, 4-bit id)
//  - AXI response/burst/cache encodings
//  - Bridge FSM state enum
package dbg_sba_axi_bridge_pkg;

  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiUserWidth = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } axi_aw_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_mst_rsp_t;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, RESP, DRAIN
  } sba_state_e;

endpackage

// File: rtl/dbg_sba_axi_bridge.sv
// Debug-module SBA memory port -> single-beat AXI4 master, one transaction
// outstanding, with a response watchdog so a hung slave cannot wedge the debugger.
// Ports:
//  clk_i, rst_ni            clock, async active-low reset
//  mem_req_i/addr/we/wdata/be  SBA request
//  mem_gnt_o                request accepted (combinational, IDLE only)
//  mem_rvalid_o/rdata/err   one-cycle response pulse; rdata/err hold until next response
//  axi_req_o / axi_rsp_i    AXI4 master channel
//  busy_o                   FSM not in IDLE
module dbg_sba_axi_bridge
  import dbg_sba_axi_bridge_pkg::*;
#(
  parameter int unsigned AddrWidth     = AxiAddrWidth,
  parameter int unsigned DataWidth     = AxiDataWidth,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   mem_req_i,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_be_i,
  output logic                   mem_gnt_o,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output axi_mst_req_t           axi_req_o,
  input  axi_mst_rsp_t           axi_rsp_i,
  output logic                   busy_o
);

  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam logic [2:0]  SizeEnc    = 3'($clog2(StrbWidth));
  localparam int unsigned TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerWidth-1:0] TimerLast =
    (TimeoutCycles == 0) ? '0 : TimerWidth'(TimeoutCycles - 1);

  sba_state_e            state;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  wdata_q;
  logic [StrbWidth-1:0]  be_q;
  logic                  aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic                  owe_b_q, owe_r_q;
  logic                  rvalid_q, err_q;
  logic [DataWidth-1:0]  rdata_q;
  logic [TimerWidth-1:0] timer_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left, ar_left;
  logic timeout, drain_done;

  assign aw_hs = aw_valid_q & axi_rsp_i.aw_ready;
  assign w_hs  = w_valid_q  & axi_rsp_i.w_ready;
  assign ar_hs = ar_valid_q & axi_rsp_i.ar_ready;
  assign b_hs  = b_ready_q  & axi_rsp_i.b_valid;
  assign r_hs  = r_ready_q  & axi_rsp_i.r_valid;

  // Address-phase handshakes still owed after the current cycle.
  assign aw_left = aw_valid_q & ~axi_rsp_i.aw_ready;
  assign w_left  = w_valid_q  & ~axi_rsp_i.w_ready;
  assign ar_left = ar_valid_q & ~axi_rsp_i.ar_ready;

  assign timeout    = (TimeoutCycles != 0) && (timer_q == TimerLast);
  assign drain_done = ~aw_left & ~w_left & ~ar_left
                    & ~(owe_b_q & ~b_hs) & ~(owe_r_q & ~r_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      owe_b_q    <= 1'b0;
      owe_r_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      timer_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      timer_q  <= '0;
      // Address/data valids drop on their own handshake in any state, so a
      // beat left pending by a timeout keeps its valid through RESP and DRAIN.
      if (aw_hs) aw_valid_q <= 1'b0;
      if (w_hs)  w_valid_q  <= 1'b0;
      if (ar_hs) ar_valid_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            be_q    <= mem_be_i;
            if (mem_we_i) begin
              state      <= WR_ADDR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state      <= RD_ADDR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (!aw_left && !w_left) begin
            state     <= WR_RESP;
            b_ready_q <= 1'b1;
          end else if (timeout) begin
            state    <= RESP;
            owe_b_q  <= 1'b1;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs || timeout) begin
            state     <= RESP;
            b_ready_q <= 1'b0;
            owe_b_q   <= ~b_hs;
            rvalid_q  <= 1'b1;
            err_q     <= ~b_hs | (axi_rsp_i.b.resp != RESP_OKAY);
            rdata_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            state     <= RD_RESP;
            r_ready_q <= 1'b1;
          end else if (timeout) begin
            state    <= RESP;
            owe_r_q  <= 1'b1;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RD_RESP: begin
          if (r_hs || timeout) begin
            state     <= RESP;
            r_ready_q <= 1'b0;
            owe_r_q   <= ~r_hs;
            rvalid_q  <= 1'b1;
            err_q     <= ~r_hs | (axi_rsp_i.r.resp != RESP_OKAY);
            rdata_q   <= r_hs ? axi_rsp_i.r.data : '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          // A timed-out transaction always owes a B or R beat.
          if (owe_b_q || owe_r_q) begin
            state     <= DRAIN;
            b_ready_q <= 1'b1;
            r_ready_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (b_hs) owe_b_q <= 1'b0;
          if (r_hs) owe_r_q <= 1'b0;
          if (drain_done) begin
            state     <= IDLE;
            b_ready_q <= 1'b0;
            r_ready_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_gnt_o    = (state == IDLE) & mem_req_i;
  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rdata_q;
  assign mem_err_o    = err_q;
  assign busy_o       = (state != IDLE);

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = SizeEnc;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw.cache = CACHE_MODIFIABLE;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = SizeEnc;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar.cache = CACHE_MODIFIABLE;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id,
                        axi_rsp_i.r.last, axi_rsp_i.r.user};

endmodule

// File: tb/tb_dbg_sba_axi_bridge.sv
// Scoreboard bench for dbg_sba_axi_bridge: stimulus pushes expected SBA
// responses; a negedge monitor pops and compares on every mem_rvalid_o.
// The AXI slave is modelled by directed tasks that check request payloads.
module tb_dbg_sba_axi_bridge;
  import dbg_sba_axi_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         mem_req, mem_we;
  logic [63:0]  mem_addr, mem_wdata;
  logic [7:0]   mem_be;
  logic         gnt, rvalid, err, busy;
  logic [63:0]  rdata;
  axi_mst_req_t axi_req;
  axi_mst_rsp_t axi_rsp;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int gnt_cnt  = 0;
  int rv_cnt   = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbg_sba_axi_bridge #(
    .AddrWidth(64),
    .DataWidth(64),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .mem_req_i(mem_req),
    .mem_addr_i(mem_addr),
    .mem_we_i(mem_we),
    .mem_wdata_i(mem_wdata),
    .mem_be_i(mem_be),
    .mem_gnt_o(gnt),
    .mem_rvalid_o(rvalid),
    .mem_rdata_o(rdata),
    .mem_err_o(err),
    .axi_req_o(axi_req),
    .axi_rsp_i(axi_rsp),
    .busy_o(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (gnt) begin
        gnt_cnt++;
        chk("gnt_while_busy", busy, 0);
      end
      if (rvalid) begin
        rv_cnt++;
        chk("rvalid_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rdata, e.rdata);
          chk("rsp_err", err, e.err);
          if (e.exp_cyc >= 0) chk("rsp_latency", cyc, e.exp_cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] be, input logic [63:0] exp_rdata,
                       input logic exp_err, input int lat);
    int n = 0;
    exp_t e;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_be = be;
    #1;
    while (!gnt && n < 50) begin tick(); n++; end
    chk("gnt_seen", gnt, 1);
    e.rdata = exp_rdata; e.err = exp_err; e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    if (gnt) sb.push_back(e);
    tick();
    mem_req = 1'b0;
  endtask

  task automatic slave_ar(input logic [63:0] addr);
    int n = 0;
    while (!axi_req.ar_valid && n < 100) begin tick(); n++; end
    chk("ar_valid_seen", axi_req.ar_valid, 1);
    chk("ar_addr", axi_req.ar.addr, addr);
    chk("ar_ctrl", {axi_req.ar.id, axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst,
                    axi_req.ar.cache}, {4'd0, 8'd0, 3'd3, 2'b01, 4'b0010});
    chk("ar_misc", {axi_req.ar.lock, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region,
                    axi_req.ar.user}, 0);
    axi_rsp.ar_ready = 1'b1;
    tick();
    axi_rsp.ar_ready = 1'b0;
    chk("ar_valid_drop", axi_req.ar_valid, 0);
  endtask

  task automatic slave_aw(input logic [63:0] addr, input int delay);
    int n = 0;
    while (!axi_req.aw_valid && n < 100) begin tick(); n++; end
    chk("aw_valid_seen", axi_req.aw_valid, 1);
    repeat (delay) tick();
    chk("aw_addr", axi_req.aw.addr, addr);
    chk("aw_ctrl", {axi_req.aw.id, axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst,
                    axi_req.aw.cache, axi_req.aw.atop}, {4'd0, 8'd0, 3'd3, 2'b01, 4'b0010, 6'd0});
    axi_rsp.aw_ready = 1'b1;
    tick();
    axi_rsp.aw_ready = 1'b0;
    chk("aw_valid_drop", axi_req.aw_valid, 0);
  endtask

  task automatic slave_w(input logic [63:0] data, input logic [7:0] strb, input int delay);
    int n = 0;
    while (!axi_req.w_valid && n < 100) begin tick(); n++; end
    chk("w_valid_seen", axi_req.w_valid, 1);
    repeat (delay) tick();
    chk("w_valid_held", axi_req.w_valid, 1);
    chk("w_data", axi_req.w.data, data);
    chk("w_strb_last", {axi_req.w.strb, axi_req.w.last}, {strb, 1'b1});
    axi_rsp.w_ready = 1'b1;
    tick();
    axi_rsp.w_ready = 1'b0;
    chk("w_valid_drop", axi_req.w_valid, 0);
  endtask

  task automatic slave_b(input logic [1:0] resp);
    int n = 0;
    axi_rsp.b_valid = 1'b1; axi_rsp.b.resp = resp;
    while (!axi_req.b_ready && n < 100) begin tick(); n++; end
    chk("b_ready_seen", axi_req.b_ready, 1);
    tick();
    axi_rsp.b_valid = 1'b0; axi_rsp.b.resp = RESP_OKAY;
  endtask

  task automatic slave_r(input logic [63:0] data, input logic [1:0] resp);
    int n = 0;
    axi_rsp.r_valid = 1'b1; axi_rsp.r.data = data; axi_rsp.r.resp = resp; axi_rsp.r.last = 1'b1;
    while (!axi_req.r_ready && n < 100) begin tick(); n++; end
    chk("r_ready_seen", axi_req.r_ready, 1);
    tick();
    axi_rsp.r_valid = 1'b0; axi_rsp.r.data = '0; axi_rsp.r.resp = RESP_OKAY;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin tick(); n++; end
    chk(name, (sb.size() == 0 && !busy), 1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk(name, {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready,
               axi_req.r_ready, busy, rvalid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int g0, r0, g_prev;
    logic [63:0] a5 [4];
    logic [63:0] d5 [4];
    a5 = '{64'h8000_1000, 64'h8000_1008, 64'h8000_2000, 64'h0000_0000_0000_0010};
    d5 = '{64'h0101_0101_0101_0101, 64'hFEDC_BA98_7654_3210, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

    rst_ni = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    axi_rsp = '0;
    repeat (3) tick();
    check_idle_outputs("reset_outputs");
    chk("reset_rsp", {rdata, err, gnt}, 0);
    rst_ni = 1'b1;
    tick();

    // 1: plain read, minimum latency
    fork
      issue(1'b0, 64'h8000_0000, '0, '0, 64'hDEAD_BEEF_0123_4567, 1'b0, 3);
      begin slave_ar(64'h8000_0000); slave_r(64'hDEAD_BEEF_0123_4567, RESP_OKAY); end
    join
    wait_done("t1_done");

    // 2: write, W accepted 5 cycles after AW, B OKAY
    fork
      issue(1'b1, 64'h8000_0100, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0, 8);
      begin
        fork
          slave_aw(64'h8000_0100, 0);
          slave_w(64'h1122_3344_5566_7788, 8'h0F, 5);
        join
        slave_b(RESP_OKAY);
      end
    join
    wait_done("t2_done");
    chk("t2_rdata_hold", rdata, 64'h0);

    // 3: AW/W same-cycle with SLVERR, then read DECERR
    fork
      issue(1'b1, 64'h8000_0180, 64'h0F0F_0F0F_0F0F_0F0F, 8'hF0, 64'h0, 1'b1, 3);
      begin
        fork
          slave_aw(64'h8000_0180, 0);
          slave_w(64'h0F0F_0F0F_0F0F_0F0F, 8'hF0, 0);
        join
        slave_b(RESP_SLVERR);
      end
    join
    wait_done("t3w_done");
    fork
      issue(1'b0, 64'h9000_0000, '0, '0, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 3);
      begin slave_ar(64'h9000_0000); slave_r(64'h0BAD_0BAD_0BAD_0BAD, RESP_DECERR); end
    join
    wait_done("t3r_done");

    // 4: read with no R -> timeout error, then drain a late R
    r0 = rv_cnt;
    fork
      issue(1'b0, 64'h8000_0040, '0, '0, 64'h0, 1'b1, 18);
      slave_ar(64'h8000_0040);
    join
    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin tick(); n++; end
      chk("t4_timeout_rsp", sb.size(), 0);
    end
    repeat (5) tick();
    chk("t4_busy_drain", {busy, axi_req.r_ready, gnt}, 3'b110);
    slave_r(64'h7777_6666_5555_4444, RESP_OKAY);
    chk("t4_busy_after_drain", busy, 0);
    repeat (3) tick();
    chk("t4_single_rvalid", rv_cnt - r0, 1);
    chk("t4_rsp_hold", {rdata, err}, {64'h0, 1'b1});

    // 5: back-to-back reads with mem_req held high
    g0 = gnt_cnt; r0 = rv_cnt; g_prev = 0;
    fork
      begin
        mem_req = 1'b1; mem_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
          int n = 0;
          exp_t e;
          mem_addr = a5[i];
          #1;
          while (!gnt && n < 50) begin tick(); n++; end
          chk("t5_gnt_seen", gnt, 1);
          if (i > 0) chk("t5_gnt_spacing", cyc - g_prev, 4);
          g_prev = cyc;
          e.rdata = d5[i]; e.err = 1'b0; e.exp_cyc = cyc + 3;
          if (gnt) sb.push_back(e);
          tick();
        end
        mem_req = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          slave_ar(a5[i]);
          slave_r(d5[i], RESP_OKAY);
        end
      end
    join
    wait_done("t5_done");
    chk("t5_gnt_count", gnt_cnt - g0, 4);
    chk("t5_rvalid_count", rv_cnt - r0, 4);

    // 6: reset asserted while waiting for B
    fork
      issue(1'b1, 64'h8000_0200, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 64'h0, 1'b0, -1);
      fork
        slave_aw(64'h8000_0200, 0);
        slave_w(64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 0);
      join
    join
    tick();
    chk("t6_in_wresp", {busy, axi_req.b_ready}, 2'b11);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check_idle_outputs("t6_reset_async");
    tick();
    check_idle_outputs("t6_reset_next");
    rst_ni = 1'b1;
    tick();
    fork
      issue(1'b0, 64'h8000_0300, '0, '0, 64'h1357_9BDF_2468_ACE0, 1'b0, 3);
      begin slave_ar(64'h8000_0300); slave_r(64'h1357_9BDF_2468_ACE0, RESP_OKAY); end
    join
    wait_done("t6_after_reset");

    repeat (3) tick();
    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
